// File: rtl/ifmux_sched_pkg.sv
// Shared widths, one-hot state encoding and saturating deficit arithmetic for the DRR interface-mux scheduler.
package ifmux_sched_pkg;

  localparam int NPORT = 4;
  localparam int QW    = 12;
  localparam int DW    = 14;
  localparam int LW    = 12;

  localparam logic signed [DW-1:0] DEF_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DEF_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_ARB    = 6'b000010,
    S_REPL   = 6'b000100,
    S_GRANT  = 6'b001000,
    S_BUSY   = 6'b010000,
    S_CHARGE = 6'b100000
  } state_t;

  // Sum is formed one bit wider; a disagreement between the top two bits means the DW-bit range was left.
  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [DW:0]   b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + b;
    if (!s[DW] && s[DW-1])      return DEF_MAX;
    else if (s[DW] && !s[DW-1]) return DEF_MIN;
    else                        return s[DW-1:0];
  endfunction

endpackage

// File: rtl/rnd_rb_ppe.sv
// Round-robin priority encoder: one-hot grant of the first requester at or after the one-hot priority position,
// wrapping around. Purely combinational.
module rnd_rb_ppe #(
  parameter int RR_WIDTH = 4
) (
  input  logic [RR_WIDTH-1:0] rr_req,
  input  logic [RR_WIDTH-1:0] rr_priority,
  output logic [RR_WIDTH-1:0] rr_gnt,
  output logic                rr_anygnt
);

  logic [2*RR_WIDTH-1:0] dreq;
  logic [2*RR_WIDTH-1:0] dgnt;

  // Subtracting the priority bit from the doubled request vector clears everything below the first hit.
  assign dreq      = {rr_req, rr_req};
  assign dgnt      = dreq & ~(dreq - {{RR_WIDTH{1'b0}}, rr_priority});
  assign rr_gnt    = dgnt[RR_WIDTH-1:0] | dgnt[2*RR_WIDTH-1:RR_WIDTH];
  assign rr_anygnt = |rr_req;

endmodule

// File: rtl/ifmux_drr_sched.sv
// Deficit-round-robin grant scheduler for the 4-port rx interface mux (quantum replenish, post-charge by length).
// Define IFMUX_SCHED_PRIO0_EN to give port 0 strict, uncharged priority.
module ifmux_drr_sched #(
  parameter int NPORT    = ifmux_sched_pkg::NPORT,
  parameter int QW       = ifmux_sched_pkg::QW,
  parameter int DW       = ifmux_sched_pkg::DW,
  parameter int LW       = ifmux_sched_pkg::LW,
  parameter int WDOG_CYC = 8192
) (
  input  logic                clk_sys,
  input  logic                rstn_sys,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT*QW-1:0] cfg_quantum,
  input  logic                gnt_req,
  output logic                gnt_vld,
  output logic [NPORT-1:0]    gnt_vec,
  output logic [1:0]          gnt_bin,
  input  logic                done,
  input  logic [LW-1:0]       done_len,
  output logic                busy,
  output logic                wdog_err
);

  import ifmux_sched_pkg::*;

  localparam int CW = $clog2(WDOG_CYC);
`ifdef IFMUX_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  state_t               state;
  logic signed [DW-1:0] deficit [NPORT];
  logic [1:0]           rr_ptr;
  logic [CW-1:0]        wdog_cnt;
  logic [LW-1:0]        len_q;

  logic [NPORT-1:0]     eligible;
  logic [NPORT-1:0]     rr_pri;
  logic [NPORT-1:0]     pick_vec;
  logic                 pick_any;
  logic [1:0]           pick_bin;
  logic signed [DW:0]   qadd [NPORT];
  logic signed [DW:0]   len_neg;
  logic                 prio_hit;
  logic                 skip_acct;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      eligible[i] = req[i] && (deficit[i] > 0);
      qadd[i]     = $signed({{(DW+1-QW){1'b0}}, cfg_quantum[i*QW +: QW]});
      if (cfg_quantum[i*QW +: QW] == '0) qadd[i] = (DW+1)'(1);
    end
    pick_bin = 2'd0;
    for (int i = 0; i < NPORT; i++) begin
      if (pick_vec[i]) pick_bin = 2'(i);
    end
    rr_pri    = NPORT'(1) << rr_ptr;
    len_neg   = -$signed({{(DW+1-LW){1'b0}}, len_q});
    prio_hit  = PRIO0 && req[0];
    // A priority port-0 grant neither pays for its bytes nor moves the round-robin pointer.
    skip_acct = PRIO0 && (gnt_bin == 2'd0);
  end

  rnd_rb_ppe #(
    .RR_WIDTH (NPORT)
  ) u_ppe (
    .rr_req      (eligible),
    .rr_priority (rr_pri),
    .rr_gnt      (pick_vec),
    .rr_anygnt   (pick_any)
  );

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state    <= S_IDLE;
      gnt_vld  <= 1'b0;
      gnt_vec  <= '0;
      gnt_bin  <= '0;
      busy     <= 1'b0;
      wdog_err <= 1'b0;
      rr_ptr   <= '0;
      wdog_cnt <= '0;
      len_q    <= '0;
      for (int i = 0; i < NPORT; i++) deficit[i] <= '0;
    end else begin
      gnt_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_req && (req != '0)) state <= S_ARB;
        end
        S_ARB: begin
          if (req == '0) begin
            state <= S_IDLE;
          end else if (prio_hit || pick_any) begin
            gnt_vec <= prio_hit ? NPORT'(1) : pick_vec;
            gnt_bin <= prio_hit ? 2'd0 : pick_bin;
            gnt_vld <= 1'b1;
            busy    <= 1'b1;
            state   <= S_GRANT;
          end else begin
            state <= S_REPL;
          end
        end
        S_REPL: begin
          for (int i = 0; i < NPORT; i++) begin
            if (req[i])              deficit[i] <= sat_add(deficit[i], qadd[i]);
            else if (deficit[i] > 0) deficit[i] <= '0;
          end
          state <= S_ARB;
        end
        S_GRANT: begin
          if (!skip_acct) rr_ptr <= gnt_bin + 2'd1;
          wdog_cnt <= '0;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          if (done) begin
            len_q <= done_len;
            state <= S_CHARGE;
          end else if (wdog_cnt == CW'(WDOG_CYC - 1)) begin
            wdog_err <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + CW'(1);
          end
        end
        S_CHARGE: begin
          if (!skip_acct) deficit[gnt_bin] <= sat_add(deficit[gnt_bin], len_neg);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmux_drr_sched.sv
// Self-checking bench for ifmux_drr_sched: directed scenarios and random frames against a DRR reference model.
module tb_ifmux_drr_sched;

  localparam int WDOG = 8192;
`ifdef IFMUX_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rstn_sys;
  logic [3:0]  req;
  logic [47:0] cfg_quantum;
  logic        gnt_req;
  logic        gnt_vld;
  logic [3:0]  gnt_vec;
  logic [1:0]  gnt_bin;
  logic        done;
  logic [11:0] done_len;
  logic        busy;
  logic        wdog_err;

  int total = 0;
  int bad   = 0;

  // Reference state: per-port deficit in bytes, quantum in bytes, next round-robin start port.
  int mdef [4];
  int mq   [4];
  int mrr;

  always #5 clk_sys = ~clk_sys;

  ifmux_drr_sched dut (
    .clk_sys     (clk_sys),
    .rstn_sys    (rstn_sys),
    .req         (req),
    .cfg_quantum (cfg_quantum),
    .gnt_req     (gnt_req),
    .gnt_vld     (gnt_vld),
    .gnt_vec     (gnt_vec),
    .gnt_bin     (gnt_bin),
    .done        (done),
    .done_len    (done_len),
    .busy        (busy),
    .wdog_err    (wdog_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int msat(input int v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  task automatic set_quanta();
    for (int i = 0; i < 4; i++) cfg_quantum[i*12 +: 12] = 12'(mq[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdef[i] = 0;
    mrr = 0;
  endtask

  // Replenish every port until some requester has positive credit, then take the first from the rr start.
  task automatic predict(input logic [3:0] r, output int port, output int passes);
    port   = -1;
    passes = 0;
    if (PRIO0 && r[0]) port = 0;
    while (port < 0 && passes < 10000) begin
      for (int k = 0; k < 4; k++) begin
        int p;
        p = (mrr + k) % 4;
        if (port < 0 && r[p] && mdef[p] > 0) port = p;
      end
      if (port < 0) begin
        passes++;
        for (int p = 0; p < 4; p++) begin
          if (r[p])             mdef[p] = msat(mdef[p] + ((mq[p] == 0) ? 1 : mq[p]));
          else if (mdef[p] > 0) mdef[p] = 0;
        end
      end
    end
  endtask

  task automatic grant(input logic [3:0] r, output int ep, output int lat);
    int np;
    predict(r, ep, np);
    req     = r;
    gnt_req = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
    end while (!gnt_vld && lat < 4000);
    gnt_req = 1'b0;
    chk("grant_latency", lat, 2 + 2 * np);
    chk("gnt_bin", int'(gnt_bin), ep);
    chk("gnt_vec", int'(gnt_vec), 1 << ep);
    if (!(PRIO0 && ep == 0)) mrr = (ep + 1) % 4;
    tick();
    chk("gnt_vld_one_cycle", int'(gnt_vld), 0);
    chk("busy_in_frame", int'(busy), 1);
  endtask

  task automatic finish(input int ep, input int len, input int hold);
    repeat (hold) tick();
    done     = 1'b1;
    done_len = 12'(len);
    tick();
    done = 1'b0;
    tick();
    chk("busy_after_charge", int'(busy), 0);
    chk("gnt_vec_held", int'(gnt_vec), 1 << ep);
    if (!(PRIO0 && ep == 0)) mdef[ep] = msat(mdef[ep] - len);
  endtask

  initial begin
    int ep, lat, n1, n3;
    rstn_sys = 1'b0;
    req      = '0;
    gnt_req  = 1'b0;
    done     = 1'b0;
    done_len = '0;
    for (int i = 0; i < 4; i++) mq[i] = 1518;
    set_quanta();
    model_reset();
    #12;
    chk("rst_gnt_vld", int'(gnt_vld), 0);
    chk("rst_gnt_vec", int'(gnt_vec), 0);
    chk("rst_gnt_bin", int'(gnt_bin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wdog_err", int'(wdog_err), 0);
    @(negedge clk_sys) rstn_sys = 1'b1;
    tick();

    // Two ports with equal quanta and short frames alternate after one replenish pass.
    for (int f = 0; f < 6; f++) begin
      grant(4'b0101, ep, lat);
      finish(ep, 64, 1);
    end

    // Request withdrawn while arbitrating: no grant, back to idle.
    req     = 4'b0001;
    gnt_req = 1'b1;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("withdraw_no_grant", int'(gnt_vld), 0);
    end
    chk("withdraw_not_busy", int'(busy), 0);
    gnt_req = 1'b0;

    // Byte fairness: quantum 3000 vs 1500 with 1500-byte frames gives a 2:1 split.
    mq[1] = 3000;
    mq[3] = 1500;
    set_quanta();
    n1 = 0;
    n3 = 0;
    for (int f = 0; f < 30; f++) begin
      grant(4'b1010, ep, lat);
      if (gnt_bin == 2'd1) n1++;
      if (gnt_bin == 2'd3) n3++;
      finish(ep, 1500, 0);
    end
    chk("fair_port1_near_20", int'(n1 >= 19 && n1 <= 21), 1);
    chk("fair_port3_near_10", int'(n3 >= 9 && n3 <= 11), 1);

    // Watchdog: no done for the full window releases the grant without charging.
    grant(4'b0010, ep, lat);
    repeat (WDOG - 1) tick();
    chk("wdog_not_yet", int'(wdog_err), 0);
    chk("busy_before_wdog", int'(busy), 1);
    tick();
    chk("wdog_err_set", int'(wdog_err), 1);
    chk("wdog_released", int'(busy), 0);
    done     = 1'b1;
    done_len = 12'd1000;
    tick();
    done = 1'b0;
    tick();
    chk("late_done_ignored", int'(busy), 0);
    grant(4'b0010, ep, lat);
    finish(ep, 200, 2);
    chk("wdog_err_sticky", int'(wdog_err), 1);

    // Asynchronous reset in the middle of a frame.
    grant(4'b1000, ep, lat);
    tick();
    rstn_sys = 1'b0;
    #1;
    chk("rst_mid_gnt_vld", int'(gnt_vld), 0);
    chk("rst_mid_gnt_vec", int'(gnt_vec), 0);
    chk("rst_mid_gnt_bin", int'(gnt_bin), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_wdog_err", int'(wdog_err), 0);
    model_reset();
    @(negedge clk_sys) rstn_sys = 1'b1;
    tick();

    // Single port, small quantum, long frame: deep negative deficit needs 23 replenish passes.
    mq[1] = 64;
    set_quanta();
    grant(4'b0010, ep, lat);
    chk("first_after_reset_repl", lat, 4);
    finish(ep, 1500, 0);
    grant(4'b0010, ep, lat);
    chk("repl_23_passes", lat, 48);
    finish(ep, 64, 0);

    // Zero quantum is treated as one byte.
    mq[2] = 0;
    set_quanta();
    grant(4'b0100, ep, lat);
    finish(ep, 0, 0);
    grant(4'b0100, ep, lat);
    chk("q0_credit_kept", lat, 2);
    finish(ep, 3, 0);
    grant(4'b0100, ep, lat);
    chk("q0_three_passes", lat, 8);
    finish(ep, 64, 0);

    // Random traffic with occasional quantum changes while idle.
    for (int f = 0; f < 60; f++) begin
      if (f % 10 == 0) begin
        for (int i = 0; i < 4; i++) mq[i] = $urandom_range(100, 3000);
        set_quanta();
      end
      grant(4'($urandom_range(1, 15)), ep, lat);
      finish(ep, $urandom_range(64, 1518), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
